// File: rtl/delay_mem_server.sv
// delay_mem_server
//   Responder side of the delay-line memory handshake. Services level-held
//   read/write requests against an internal single-port RAM of memory_size
//   words. Each request gets one pulse back: mem_write_ack for a write or
//   mem_read_valid for a read. After reset the RAM can optionally be
//   zero-filled, so that fresh delay lines start silent.
//
//   Ports
//     clk            system clock
//     reset_n        asynchronous active-low reset
//     mem_read_req   read request, held until mem_read_valid
//     mem_read_addr  read address, stable while mem_read_req is high
//     mem_write_req  write request, held until mem_write_ack
//     mem_write_addr write address, stable while mem_write_req is high
//     mem_write_data write data, stable while mem_write_req is high
//     mem_read_data  last read result, held until the next read completes
//     mem_read_valid one-cycle pulse: mem_read_data has just been updated
//     mem_write_ack  one-cycle pulse: the write has been committed
//     addr_error     one-cycle pulse with ack/valid when address >= memory_size
//     busy           high while the zero-fill runs
module delay_mem_server #(
  parameter int data_width     = 16,
  parameter int memory_size    = 8192,
  parameter int read_latency   = 2,
  parameter int clear_on_reset = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            mem_read_req,
  input  logic [$clog2(memory_size)-1:0]  mem_read_addr,
  input  logic                            mem_write_req,
  input  logic [$clog2(memory_size)-1:0]  mem_write_addr,
  input  logic signed [data_width-1:0]    mem_write_data,
  output logic signed [data_width-1:0]    mem_read_data,
  output logic                            mem_read_valid,
  output logic                            mem_write_ack,
  output logic                            addr_error,
  output logic                            busy
);

  localparam int addr_width = $clog2(memory_size);
  localparam logic [addr_width-1:0] last_addr = addr_width'(memory_size - 1);
  localparam logic [2:0] lat_init = 3'(read_latency - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, W_ACK, R_WAIT, R_VALID} state_t;

  state_t                         state, state_next;
  logic [addr_width-1:0]          fill_cnt;
  logic [2:0]                     lat_cnt;
  logic                           oor_q;
  logic                           busy_q;

  logic                           ram_we, ram_re;
  logic [addr_width-1:0]          ram_addr;
  logic signed [data_width-1:0]   ram_wdata;
  logic signed [data_width-1:0]   ram_rd_p1;
  logic signed [data_width-1:0]   mem [memory_size];

  function automatic logic out_of_range(input logic [addr_width-1:0] a);
    return 32'(a) >= 32'(memory_size);
  endfunction

  // Single-port RAM: one address shared by the fill, the write and the read.
  // Not reset: contents survive reset unless the zero-fill overwrites them.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rd_p1 <= mem[ram_addr];
  end

  // Next state and RAM port control. Requests are looked at only in IDLE;
  // in W_ACK/R_VALID the requester is still high and must not be re-served.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = fill_cnt;
    ram_wdata  = '0;
    case (state)
      CLEAR: begin
        // busy_q low marks the first cycle out of reset: busy is raised
        // there and the fill writes run on the following memory_size edges.
        if (busy_q) begin
          ram_we = 1'b1;
          if (fill_cnt == last_addr) state_next = IDLE;
        end
      end
      IDLE: begin
        if (mem_write_req) begin
          ram_addr   = mem_write_addr;
          ram_wdata  = mem_write_data;
          ram_we     = !out_of_range(mem_write_addr);
          state_next = W_ACK;
        end else if (mem_read_req) begin
          ram_addr   = mem_read_addr;
          ram_re     = !out_of_range(mem_read_addr);
          state_next = R_WAIT;
        end
      end
      W_ACK:   state_next = IDLE;
      R_WAIT:  if (lat_cnt == 3'd0) state_next = R_VALID;
      R_VALID: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= (clear_on_reset != 0) ? CLEAR : IDLE;
      fill_cnt      <= '0;
      busy_q        <= 1'b0;
      lat_cnt       <= '0;
      oor_q         <= 1'b0;
      mem_read_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        CLEAR: begin
          if (!busy_q) begin
            busy_q <= 1'b1;
          end else if (fill_cnt == last_addr) begin
            busy_q   <= 1'b0;
            fill_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (mem_write_req) begin
            oor_q <= out_of_range(mem_write_addr);
          end else if (mem_read_req) begin
            oor_q   <= out_of_range(mem_read_addr);
            lat_cnt <= lat_init;
          end
        end
        R_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          // Out-of-range reads never touched the RAM; return silence.
          if (lat_cnt == 3'd0) mem_read_data <= oor_q ? '0 : ram_rd_p1;
        end
        default: ;
      endcase
    end
  end

  assign mem_write_ack  = (state == W_ACK);
  assign mem_read_valid = (state == R_VALID);
  assign addr_error     = oor_q && ((state == W_ACK) || (state == R_VALID));
  assign busy           = busy_q;

endmodule

// File: tb/tb_delay_mem_server.sv
// tb_delay_mem_server
//   Drives the server as a well-behaved requester and checks every cycle
//   against an edge-indexed schedule of expected pulses produced from the
//   handshake timing rules, plus a word array standing in for the RAM.
module tb_delay_mem_server;

  localparam int DW   = 16;
  localparam int MS   = 12;
  localparam int RL   = 2;
  localparam int AW   = $clog2(MS);
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read_req = 1'b0;
  logic [AW-1:0] mem_read_addr = '0;
  logic          mem_write_req = 1'b0;
  logic [AW-1:0] mem_write_addr = '0;
  logic [DW-1:0] mem_write_data = '0;
  logic [DW-1:0] mem_read_data;
  logic          mem_read_valid;
  logic          mem_write_ack;
  logic          addr_error;
  logic          busy;

  delay_mem_server #(
    .data_width(DW), .memory_size(MS), .read_latency(RL), .clear_on_reset(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .mem_write_ack(mem_write_ack), .addr_error(addr_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge (first edge is 1).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the cycle that follows edge k.
  bit            e_ack [MAXC];
  bit            e_val [MAXC];
  bit            e_err [MAXC];
  bit            e_busy[MAXC];
  logic [DW-1:0] e_rd  [MAXC];
  logic [DW-1:0] mdl_mem[16];
  logic [DW-1:0] cur_rd = '0;
  int            next_free = 0;

  int compared = 0, mismatched = 0;
  int n_ack = 0, n_val = 0, n_err = 0, n_busy = 0;
  int last_ack_edge = 0, last_val_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit mdl_oor(input int a);
    return a >= MS;
  endfunction

  task automatic mdl_reset_assert();
    for (int k = cyc; k < MAXC; k++) begin
      e_ack[k] = 0; e_val[k] = 0; e_err[k] = 0; e_busy[k] = 0;
    end
    cur_rd = '0;
  endtask

  // Reset released before edge cyc+1: busy for MS cycles, RAM all zero,
  // first request sampled one edge after busy falls.
  task automatic mdl_release();
    int a;
    a = cyc + 1;
    for (int k = a; k < a + MS; k++) e_busy[k] = 1;
    next_free = a + MS + 1;
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
  endtask

  // Issue a write, a read, or both (write served first). Called just after
  // a falling edge; returns at the falling edge after the last request drops.
  task automatic do_op(input bit w, input int waddr, input logic [DW-1:0] wdata,
                       input bit r, input int raddr);
    int t, k, drop_w, drop_r;
    drop_w = 0;
    drop_r = 0;
    t = cyc + 1;
    if (next_free > t) t = next_free;
    if (w) begin
      e_ack[t] = 1;
      e_err[t] = mdl_oor(waddr);
      if (!mdl_oor(waddr)) mdl_mem[waddr] = wdata;
      drop_w = t + 1;
      t = t + 2;
    end
    if (r) begin
      k = t + RL;
      e_val[k] = 1;
      e_err[k] = mdl_oor(raddr);
      e_rd[k]  = mdl_oor(raddr) ? '0 : mdl_mem[raddr];
      drop_r = k + 1;
      t = k + 1;
    end
    next_free = t;
    mem_write_addr = AW'(waddr);
    mem_write_data = wdata;
    mem_read_addr  = AW'(raddr);
    mem_write_req  = w;
    mem_read_req   = r;
    while (mem_write_req || mem_read_req) begin
      @(negedge clk);
      if (cyc >= drop_w) mem_write_req = 1'b0;
      if (cyc >= drop_r) mem_read_req  = 1'b0;
    end
  endtask

  // Per-cycle compare against the schedule.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      if (cyc < MAXC) begin
        if (e_val[cyc]) cur_rd = e_rd[cyc];
        check("ack",        32'(mem_write_ack),  32'(e_ack[cyc]));
        check("valid",      32'(mem_read_valid), 32'(e_val[cyc]));
        check("addr_error", 32'(addr_error),     32'(e_err[cyc]));
        check("busy",       32'(busy),           32'(e_busy[cyc]));
        check("read_data",  32'(mem_read_data),  32'(cur_rd));
      end
      if (mem_write_ack)  begin n_ack++; last_ack_edge = cyc; end
      if (mem_read_valid) begin n_val++; last_val_edge = cyc; end
      if (addr_error) n_err++;
      if (busy) n_busy++;
    end
  end

  initial begin
    int c0, v0, a0, b0, op, wa, ra;

    // Power-up reset, then a read of addr 5 raised while the fill runs.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mdl_release();
    do_op(0, 0, '0, 1, 5);
    check("t1_busy_cycles", 32'(n_busy), 32'(12));
    check("t1_read5",       32'(mem_read_data), 32'h0);

    // Write 0x7FFF to addr 3, read it back.
    c0 = cyc;
    do_op(1, 3, 16'h7FFF, 0, 0);
    check("t2_ack_latency", 32'(last_ack_edge - c0), 32'(1));
    c0 = cyc;
    do_op(0, 0, '0, 1, 3);
    check("t2_valid_latency", 32'(last_val_edge - (c0 + 1)), 32'(2));
    check("t2_data",          32'(mem_read_data), 32'h7FFF);

    // Write held through the ack cycle: exactly one ack.
    a0 = n_ack;
    do_op(1, 9, 16'h8001, 0, 0);
    repeat (3) @(negedge clk);
    check("t3_single_ack", 32'(n_ack - a0), 32'(1));
    do_op(0, 0, '0, 1, 9);
    check("t3_data", 32'(mem_read_data), 32'h8001);

    // Simultaneous write and read of the same address.
    do_op(1, 7, 16'h1234, 1, 7);
    check("t4_data",       32'(mem_read_data), 32'h1234);
    check("t4_write_first", 32'(last_val_edge > last_ack_edge), 32'(1));

    // Out-of-range accesses.
    v0 = n_err;
    do_op(0, 0, '0, 1, 14);
    check("t5_oor_read_data", 32'(mem_read_data), 32'h0);
    check("t5_oor_read_err",  32'(n_err - v0), 32'(1));
    do_op(1, 13, 16'hBEEF, 0, 0);
    check("t5_oor_write_err", 32'(n_err - v0), 32'(2));
    do_op(0, 0, '0, 1, 1);
    check("t5_addr1_untouched", 32'(mem_read_data), 32'h0);

    // Reset during R_WAIT.
    do_op(0, 0, '0, 1, 3);
    v0 = n_val;
    mem_read_addr = AW'(2);
    mem_read_req  = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    mem_read_req = 1'b0;
    mdl_reset_assert();
    #1;
    check("t6_valid_in_reset", 32'(mem_read_valid), 32'(0));
    check("t6_rdata_in_reset", 32'(mem_read_data),  32'h0);
    check("t6_busy_in_reset",  32'(busy),           32'(0));
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    mdl_release();
    b0 = n_busy;
    repeat (MS + 3) @(negedge clk);
    check("t6_no_valid",   32'(n_val - v0), 32'(0));
    check("t6_busy_again", 32'(n_busy - b0), 32'(12));

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 2));
      wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      do_op(op != 1, wa, DW'($urandom), op != 0, ra);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
